// File: rtl/wb_multi_lane_stage_if.sv
// MEM -> WB bundle channel plus the WB -> register-file write port.
//
// Handshake: MEM holds ms_to_ws_valid and ms_to_ws_bus stable while offering a
// bundle; the bundle is transferred on a rising clk edge where
// ms_to_ws_valid && ws_allowin. ws_allowin never depends on ms_to_ws_valid.
// ws_to_rf_bus = {rf_we, rf_waddr, rf_wdata}; only meaningful when rf_we=1.
interface wb_multi_lane_stage_if #(
  parameter int NUM_LANES = 2,
  parameter int XLEN      = 32,
  parameter int RF_AW     = 5,
  parameter int PC_W      = 32
);
  localparam int LANE_W = 2 + RF_AW + XLEN + PC_W;

  logic                        ws_allowin;
  logic                        ms_to_ws_valid;
  logic [NUM_LANES*LANE_W-1:0] ms_to_ws_bus;
  logic [RF_AW+XLEN:0]         ws_to_rf_bus;

  // MEM side (and the RF it feeds): offers bundles, observes allowin and RF writes.
  modport master (
    output ms_to_ws_valid,
    output ms_to_ws_bus,
    input  ws_allowin,
    input  ws_to_rf_bus
  );

  // WB stage side.
  modport slave (
    input  ms_to_ws_valid,
    input  ms_to_ws_bus,
    output ws_allowin,
    output ws_to_rf_bus
  );
endinterface

// File: rtl/wb_multi_lane_stage.sv
// Multi-lane write-back stage. Captures one bundle of NUM_LANES retiring
// instructions, drains its RF writes one per cycle in lane order through the
// single RF write port, and counts retired instructions.
// Lane layout (lane0 at LSB of the bus): {lv, we, dest[RF_AW], result[XLEN], pc[PC_W]}.
// Optional feature: define WB_DEBUG_TRACE_EN to add the debug_wb_* trace ports.
module wb_multi_lane_stage #(
  parameter int NUM_LANES = 2,
  parameter int XLEN      = 32,
  parameter int RF_AW     = 5,
  parameter int PC_W      = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  wb_multi_lane_stage_if.slave    ms_if,
  input  logic                    ws_flush,
  output logic [63:0]             ws_instret
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [PC_W-1:0]         debug_wb_pc,
  output logic [3:0]              debug_wb_rf_wen,
  output logic [RF_AW-1:0]        debug_wb_rf_wnum,
  output logic [XLEN-1:0]         debug_wb_rf_wdata
`endif
);

  localparam int LANE_W = 2 + RF_AW + XLEN + PC_W;
  localparam int IDX_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  // Incoming bundle, unpacked per lane
  logic [NUM_LANES-1:0] in_lv;
  logic [NUM_LANES-1:0] in_we;
  logic [RF_AW-1:0]     in_dest   [NUM_LANES];
  logic [XLEN-1:0]      in_result [NUM_LANES];
  logic [PC_W-1:0]      in_pc     [NUM_LANES];
  logic [NUM_LANES-1:0] cap_mask;

  // Registered bundle and drain state
  logic                 ws_valid;
  logic [NUM_LANES-1:0] pend_mask;
  logic [NUM_LANES-1:0] lv_r;
  logic [RF_AW-1:0]     dest_r    [NUM_LANES];
  logic [XLEN-1:0]      result_r  [NUM_LANES];
`ifdef WB_DEBUG_TRACE_EN
  logic [PC_W-1:0]      pc_r      [NUM_LANES];
`endif

  // Drain control
  logic [IDX_W-1:0]     sel_idx;
  logic [NUM_LANES-1:0] sel_onehot;
  logic [2:0]           pend_cnt;
  logic [2:0]           lv_cnt;
  logic                 ws_ready_go;
  logic                 capture;
  logic                 rf_we;
  logic [RF_AW-1:0]     rf_waddr;
  logic [XLEN-1:0]      rf_wdata;

  // Split the MEM bus into per-lane fields
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      in_pc[i]     = ms_if.ms_to_ws_bus[i*LANE_W +: PC_W];
      in_result[i] = ms_if.ms_to_ws_bus[i*LANE_W + PC_W +: XLEN];
      in_dest[i]   = ms_if.ms_to_ws_bus[i*LANE_W + PC_W + XLEN +: RF_AW];
      in_we[i]     = ms_if.ms_to_ws_bus[i*LANE_W + PC_W + XLEN + RF_AW];
      in_lv[i]     = ms_if.ms_to_ws_bus[i*LANE_W + LANE_W - 1];
    end
  end

  // Pending-write mask at capture: drop r0 writes and every lane overwritten by a younger lane
  always_comb begin
    logic keep;
    cap_mask = '0;
    keep     = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      keep = in_lv[i] & in_we[i] & (in_dest[i] != '0);
      for (int j = i + 1; j < NUM_LANES; j++) begin
        if (in_lv[j] && in_we[j] && (in_dest[j] == in_dest[i])) keep = 1'b0;
      end
      cap_mask[i] = keep;
    end
  end

  // Lowest pending lane, pending count and retiring-lane count
  always_comb begin
    sel_idx    = '0;
    sel_onehot = '0;
    pend_cnt   = '0;
    lv_cnt     = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (pend_mask[i]) begin
        sel_idx    = IDX_W'(i);
        sel_onehot = '0;
        sel_onehot[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      pend_cnt = pend_cnt + {2'b00, pend_mask[i]};
      lv_cnt   = lv_cnt + {2'b00, lv_r[i]};
    end
  end

  // Handshake and RF port; flush (and reset) suppress any write in the current cycle
  always_comb begin
    ws_ready_go       = ws_valid && (pend_cnt <= 3'd1);
    ms_if.ws_allowin  = !ws_flush && (!ws_valid || ws_ready_go);
    capture           = ms_if.ms_to_ws_valid && ms_if.ws_allowin;
    rf_we             = ws_valid && (pend_cnt != 3'd0) && !ws_flush && !reset;
    rf_waddr          = dest_r[sel_idx];
    rf_wdata          = result_r[sel_idx];
    ms_if.ws_to_rf_bus = {rf_we, rf_waddr, rf_wdata};
  end

  // Bundle capture, per-cycle drain, flush and retired-instruction count
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid   <= 1'b0;
      pend_mask  <= '0;
      lv_r       <= '0;
      ws_instret <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        dest_r[i]   <= '0;
        result_r[i] <= '0;
`ifdef WB_DEBUG_TRACE_EN
        pc_r[i]     <= '0;
`endif
      end
    end else if (ws_flush) begin
      ws_valid  <= 1'b0;
      pend_mask <= '0;
    end else begin
      if (capture) begin
        ws_valid  <= 1'b1;
        pend_mask <= cap_mask;
        lv_r      <= in_lv;
        for (int i = 0; i < NUM_LANES; i++) begin
          dest_r[i]   <= in_dest[i];
          result_r[i] <= in_result[i];
`ifdef WB_DEBUG_TRACE_EN
          pc_r[i]     <= in_pc[i];
`endif
        end
      end else begin
        if (ws_ready_go) ws_valid <= 1'b0;
        if (rf_we) pend_mask <= pend_mask & ~sel_onehot;
      end
      if (ws_ready_go) ws_instret <= ws_instret + {61'd0, lv_cnt};
    end
  end

`ifdef WB_DEBUG_TRACE_EN
  // Trace port: one record per actual RF write, lane0 pc when idle
  always_comb begin
    debug_wb_pc       = rf_we ? pc_r[sel_idx] : pc_r[0];
    debug_wb_rf_wen   = {4{rf_we}};
    debug_wb_rf_wnum  = rf_waddr;
    debug_wb_rf_wdata = rf_wdata;
  end
`else
  // PCs are only needed by the trace port
  logic unused_in_pc;
  always_comb begin
    unused_in_pc = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) unused_in_pc = unused_in_pc ^ (^in_pc[i]);
  end
`endif

endmodule

// File: tb/tb_wb_multi_lane_stage.sv
// Directed bench for wb_multi_lane_stage with NUM_LANES=2: reset, in-order drain,
// intra-bundle WAW, r0 suppression, empty bundle, back-to-back bundles,
// flush mid-drain and reset mid-drain.
module tb_wb_multi_lane_stage;
  localparam int NUM_LANES = 2;
  localparam int XLEN      = 32;
  localparam int RF_AW     = 5;
  localparam int PC_W      = 32;
  localparam int LANE_W    = 2 + RF_AW + XLEN + PC_W;

  logic        clk;
  logic        reset;
  logic        ws_flush;
  logic [63:0] ws_instret;
  logic        rf_we;
  logic [RF_AW-1:0] rf_waddr;
  logic [XLEN-1:0]  rf_wdata;
`ifdef WB_DEBUG_TRACE_EN
  logic [PC_W-1:0]  debug_wb_pc;
  logic [3:0]       debug_wb_rf_wen;
  logic [RF_AW-1:0] debug_wb_rf_wnum;
  logic [XLEN-1:0]  debug_wb_rf_wdata;
`endif

  int n_checks;
  int n_pass;
  bit done;
  logic [RF_AW+XLEN-1:0] exp_q[$];

  wb_multi_lane_stage_if #(
    .NUM_LANES(NUM_LANES), .XLEN(XLEN), .RF_AW(RF_AW), .PC_W(PC_W)
  ) bus_if ();

  wb_multi_lane_stage #(
    .NUM_LANES(NUM_LANES), .XLEN(XLEN), .RF_AW(RF_AW), .PC_W(PC_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .ms_if             (bus_if.slave),
    .ws_flush          (ws_flush),
    .ws_instret        (ws_instret)
`ifdef WB_DEBUG_TRACE_EN
    ,
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
  );

  assign {rf_we, rf_waddr, rf_wdata} = bus_if.ws_to_rf_bus;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // driver helpers
  function automatic logic [LANE_W-1:0] mk_lane(input logic lv, input logic we,
                                                input logic [RF_AW-1:0] dest,
                                                input logic [XLEN-1:0] res,
                                                input logic [PC_W-1:0] pc);
    return {lv, we, dest, res, pc};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clk);
  endtask

  task automatic offer(input logic [LANE_W-1:0] l1, input logic [LANE_W-1:0] l0);
    bus_if.ms_to_ws_bus   = {l1, l0};
    bus_if.ms_to_ws_valid = 1'b1;
  endtask

  // scoreboard: every RF write must match the next expected write
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) check("wr_unexpected", {27'd0, rf_waddr, rf_wdata}, 64'd0);
      else check("wr_addr_data", {27'd0, rf_waddr, rf_wdata}, {27'd0, exp_q.pop_front()});
    end
  end

  // watchdog
  initial begin
    #100000;
    if (!done) begin
      n_checks++;
      $display("FAIL timeout: got no end expected end by 100000");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    done     = 1'b0;
    reset    = 1'b1;
    ws_flush = 1'b0;
    bus_if.ms_to_ws_valid = 1'b0;
    bus_if.ms_to_ws_bus   = '0;

    // 1: reset
    repeat (3) next_cycle();
    reset = 1'b0;
    at_sample();
    check("rst_allowin", bus_if.ws_allowin, 1);
    check("rst_rf_we", rf_we, 0);
    check("rst_instret", ws_instret, 0);
    next_cycle();

    // 2: two writes drained in lane order
    offer(mk_lane(1, 1, 5'd5, 32'h22, 32'h1c000004), mk_lane(1, 1, 5'd3, 32'h11, 32'h1c000000));
    exp_q.push_back({5'd3, 32'h11});
    exp_q.push_back({5'd5, 32'h22});
    at_sample();
    check("t2_allowin_idle", bus_if.ws_allowin, 1);
    next_cycle();
    bus_if.ms_to_ws_valid = 1'b0;
    at_sample();
    check("t2_c1_we", rf_we, 1);
    check("t2_c1_allowin", bus_if.ws_allowin, 0);
`ifdef WB_DEBUG_TRACE_EN
    check("t2_c1_dbg_pc", debug_wb_pc, 64'h1c000000);
    check("t2_c1_dbg_wen", debug_wb_rf_wen, 4'hf);
`endif
    next_cycle();
    at_sample();
    check("t2_c2_we", rf_we, 1);
    check("t2_c2_allowin", bus_if.ws_allowin, 1);
`ifdef WB_DEBUG_TRACE_EN
    check("t2_c2_dbg_pc", debug_wb_pc, 64'h1c000004);
`endif
    next_cycle();
    at_sample();
    check("t2_idle_we", rf_we, 0);
    check("t2_instret", ws_instret, 2);
    next_cycle();

    // 3: WAW inside a bundle keeps only the youngest lane
    offer(mk_lane(1, 1, 5'd7, 32'hBB, 32'h1c000014), mk_lane(1, 1, 5'd7, 32'hAA, 32'h1c000010));
    exp_q.push_back({5'd7, 32'hBB});
    next_cycle();
    bus_if.ms_to_ws_valid = 1'b0;
    at_sample();
    check("t3_we", rf_we, 1);
    check("t3_allowin", bus_if.ws_allowin, 1);
    next_cycle();
    at_sample();
    check("t3_idle_we", rf_we, 0);
    check("t3_instret", ws_instret, 4);
    next_cycle();

    // 4: r0 write and we=0 lane -> no write, one cycle
    offer(mk_lane(1, 0, 5'd9, 32'h99, 32'h1c000024), mk_lane(1, 1, 5'd0, 32'h55, 32'h1c000020));
    next_cycle();
    bus_if.ms_to_ws_valid = 1'b0;
    at_sample();
    check("t4_we", rf_we, 0);
    check("t4_allowin", bus_if.ws_allowin, 1);
    next_cycle();
    at_sample();
    check("t4_instret", ws_instret, 6);
    next_cycle();

    // 4b: bundle with no live lanes
    offer(mk_lane(0, 1, 5'd4, 32'h44, 32'h0), mk_lane(0, 1, 5'd6, 32'h66, 32'h0));
    next_cycle();
    bus_if.ms_to_ws_valid = 1'b0;
    at_sample();
    check("t4b_we", rf_we, 0);
    check("t4b_allowin", bus_if.ws_allowin, 1);
    next_cycle();
    at_sample();
    check("t4b_instret", ws_instret, 6);
    next_cycle();

    // 5: back-to-back bundles, valid held high
    offer(mk_lane(1, 1, 5'd2, 32'h2, 32'h100), mk_lane(1, 1, 5'd1, 32'h1, 32'h104));
    exp_q.push_back({5'd1, 32'h1});
    exp_q.push_back({5'd2, 32'h2});
    exp_q.push_back({5'd4, 32'h4});
    exp_q.push_back({5'd6, 32'h6});
    next_cycle();
    offer(mk_lane(1, 1, 5'd6, 32'h6, 32'h10c), mk_lane(1, 1, 5'd4, 32'h4, 32'h108));
    at_sample();
    check("t5_a0_we", rf_we, 1);
    check("t5_a0_allowin", bus_if.ws_allowin, 0);
    next_cycle();
    at_sample();
    check("t5_a1_we", rf_we, 1);
    check("t5_a1_allowin", bus_if.ws_allowin, 1);
    next_cycle();
    bus_if.ms_to_ws_valid = 1'b0;
    at_sample();
    check("t5_b0_we", rf_we, 1);
    check("t5_b0_allowin", bus_if.ws_allowin, 0);
    check("t5_a_instret", ws_instret, 8);
    next_cycle();
    at_sample();
    check("t5_b1_we", rf_we, 1);
    next_cycle();
    at_sample();
    check("t5_idle_we", rf_we, 0);
    check("t5_instret", ws_instret, 10);
    next_cycle();

    // 6: flush while lane0 is pending; an offered bundle must not be taken
    offer(mk_lane(1, 1, 5'd9, 32'h90, 32'h200), mk_lane(1, 1, 5'd8, 32'h80, 32'h204));
    next_cycle();
    offer(mk_lane(1, 1, 5'd13, 32'hD0, 32'h20c), mk_lane(1, 1, 5'd12, 32'hC0, 32'h208));
    ws_flush = 1'b1;
    at_sample();
    check("t6_flush_we", rf_we, 0);
    check("t6_flush_allowin", bus_if.ws_allowin, 0);
    next_cycle();
    ws_flush = 1'b0;
    bus_if.ms_to_ws_valid = 1'b0;
    at_sample();
    check("t6_post_we", rf_we, 0);
    check("t6_post_allowin", bus_if.ws_allowin, 1);
    check("t6_instret", ws_instret, 10);
    next_cycle();
    at_sample();
    check("t6_post2_we", rf_we, 0);
    next_cycle();

    // 7: reset after the first write of a two-write bundle
    offer(mk_lane(1, 1, 5'd11, 32'hB1, 32'h300), mk_lane(1, 1, 5'd10, 32'hA1, 32'h304));
    exp_q.push_back({5'd10, 32'hA1});
    next_cycle();
    bus_if.ms_to_ws_valid = 1'b0;
    at_sample();
    check("t7_c1_we", rf_we, 1);
    next_cycle();
    reset = 1'b1;
    at_sample();
    check("t7_rst_we", rf_we, 0);
    next_cycle();
    reset = 1'b0;
    at_sample();
    check("t7_post_we", rf_we, 0);
    check("t7_post_allowin", bus_if.ws_allowin, 1);
    check("t7_instret", ws_instret, 0);
    next_cycle();
    repeat (2) next_cycle();

    // final report
    check("exp_q_empty", exp_q.size(), 0);
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
